// File: rtl/counter_step_pkg.sv
// counter_step_pkg: FSM states, step classes and candidate-step type shared by the step decoder
package counter_step_pkg;
    localparam int CAND_W = 16;
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DN, STEP_JUMP} step_t;
    typedef struct packed {
        logic              dir;
        logic [CAND_W-1:0] delta;
    } cand_t;
endpackage

// File: rtl/counter_step_decoder_classifier.sv
// step_classifier: classifies prev->cin as HOLD/UP/DN/JUMP with modulo delta; in prev, cin; out cls, delta
module step_classifier
    import counter_step_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int INCR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] prev,
    input  logic [ADDR_WIDTH-1:0] cin,
    output step_t                 cls,
    output logic [INCR_WIDTH-1:0] delta
);
    logic [ADDR_WIDTH-1:0] d_up, d_dn;
    logic                  up_ok, dn_ok;
    always_comb begin
        d_up  = cin - prev;
        d_dn  = prev - cin;
        up_ok = |d_up && ~|d_up[ADDR_WIDTH-1:INCR_WIDTH];
        dn_ok = |d_dn && ~|d_dn[ADDR_WIDTH-1:INCR_WIDTH];
        delta = up_ok ? d_up[INCR_WIDTH-1:0] : d_dn[INCR_WIDTH-1:0];
        cls   = cin == prev ? STEP_HOLD : up_ok ? STEP_UP : dn_ok ? STEP_DN : STEP_JUMP;
    end
endmodule

// File: rtl/counter_step_decoder.sv
// counter_step_decoder: passive monitor decoding counter motion into step, direction, stall and jump status
// in: clk, reset (async active-low), clear, cin_valid, cin
// out: incr_est, updn_est, locked, stalled, jump, jump_count
module counter_step_decoder
    import counter_step_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int INCR_WIDTH = 4,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  cin_valid,
    input  logic [ADDR_WIDTH-1:0] cin,
    output logic [INCR_WIDTH-1:0] incr_est,
    output logic                  updn_est,
    output logic                  locked,
    output logic                  stalled,
    output logic                  jump,
    output logic [CNT_WIDTH-1:0]  jump_count
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    state_t                state, state_n;
    step_t                 cls;
    cand_t                 cand, cand_n, step;
    logic [ADDR_WIDTH-1:0] prev;
    logic [INCR_WIDTH-1:0] delta;
    logic [3:0]            run, run_n;
    logic                  jumped, jumped_n, match, load_est, is_jump;
    step_classifier #(.ADDR_WIDTH(ADDR_WIDTH), .INCR_WIDTH(INCR_WIDTH)) u_cls (
        .prev  (prev),
        .cin   (cin),
        .cls   (cls),
        .delta (delta)
    );
    // jumped remembers an unanswered JUMP while locked so a single preload is tolerated
    always_comb begin
        step.dir   = cls == STEP_DN;
        step.delta = CAND_W'(delta);
        match      = step == cand;
        is_jump    = state != IDLE && cls == STEP_JUMP;
        state_n    = state;
        run_n      = run;
        cand_n     = cand;
        jumped_n   = jumped;
        load_est   = 1'b0;
        case (state)
            IDLE: begin
                state_n = ACQUIRE;
                run_n   = '0;
            end
            ACQUIRE: begin
                if (cls == STEP_JUMP) run_n = '0;
                else if (cls != STEP_HOLD && !match) begin
                    cand_n = step;
                    run_n  = 4'd1;
                end else if (cls != STEP_HOLD) begin
                    run_n = run + 4'd1;
                    if (run_n == LOCK_N) begin
                        state_n  = LOCKED;
                        load_est = 1'b1;
                        jumped_n = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (cls == STEP_JUMP) begin
                    jumped_n = !jumped;
                    if (jumped) begin
                        state_n = ACQUIRE;
                        run_n   = '0;
                    end
                end else if (cls != STEP_HOLD) begin
                    jumped_n = 1'b0;
                    if (!match) begin
                        state_n = ACQUIRE;
                        cand_n  = step;
                        run_n   = 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev       <= '0;
            cand       <= '0;
            run        <= '0;
            jumped     <= 1'b0;
            incr_est   <= '0;
            updn_est   <= 1'b0;
            stalled    <= 1'b0;
            jump       <= 1'b0;
            jump_count <= '0;
        end else begin
            jump <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                run        <= '0;
                jumped     <= 1'b0;
                jump_count <= '0;
            end else if (cin_valid) begin
                state   <= state_n;
                run     <= run_n;
                cand    <= cand_n;
                jumped  <= jumped_n;
                prev    <= cin;
                stalled <= state != IDLE && cls == STEP_HOLD;
                jump    <= is_jump;
                if (is_jump && !(&jump_count)) jump_count <= jump_count + CNT_WIDTH'(1);
                if (load_est) begin
                    incr_est <= cand.delta[INCR_WIDTH-1:0];
                    updn_est <= cand.dir;
                end
            end
        end
    end
    assign locked = state == LOCKED;
endmodule
